// File: rtl/nios_3pio_timer_sequencer_pkg.sv
// Shared definitions for the 3-PIO interval timer sequencer: timer register map,
// control bit positions and FSM state encoding.
package nios_3pio_timer_sequencer_pkg;

  localparam logic [2:0] TMR_STATUS  = 3'd0;
  localparam logic [2:0] TMR_CONTROL = 3'd1;
  localparam logic [2:0] TMR_PERIODL = 3'd2;
  localparam logic [2:0] TMR_PERIODH = 3'd3;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE    = 4'd0;
  localparam state_t ST_WR_PL   = 4'd1;
  localparam state_t ST_WR_PH   = 4'd2;
  localparam state_t ST_WR_CLR  = 4'd3;
  localparam state_t ST_WR_CTRL = 4'd4;
  localparam state_t ST_RUN     = 4'd5;
  localparam state_t ST_ACK     = 4'd6;
  localparam state_t ST_WR_STOP = 4'd7;
  localparam state_t ST_WR_FIN  = 4'd8;

  function automatic logic [15:0] ctrl_word(input logic ito, input logic cont,
                                            input logic start, input logic stop);
    logic [15:0] w;
    w             = '0;
    w[CTRL_ITO]   = ito;
    w[CTRL_CONT]  = cont;
    w[CTRL_START] = start;
    w[CTRL_STOP]  = stop;
    return w;
  endfunction

endpackage

// File: rtl/nios_3pio_timer_sequencer_if.sv
// Avalon-MM write-only link between the sequencer (master) and the interval timer
// slave, plus the timer's level interrupt back to the master.
interface nios_3pio_timer_sequencer_if;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic        tmr_irq;

  modport master (
    output tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
    input  tmr_irq
  );

  modport slave (
    input  tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
    output tmr_irq
  );
endinterface

// File: rtl/nios_3pio_timer_sequencer.sv
// Programs the interval timer, acknowledges each timeout and turns it into a
// one-cycle tick plus a wrapping tick counter.
//
// state      | meaning
// IDLE       | bus idle, waiting for start
// WR_PL      | write period low half
// WR_PH      | write period high half
// WR_CLR     | clear any stale timeout
// WR_CTRL    | enable interrupt, set mode, start timer
// RUN        | wait for timeout or stop
// ACK        | clear timeout, emit tick
// WR_STOP    | stop timer, disable interrupt
// WR_FIN     | final status clear, back to IDLE
module nios_3pio_timer_sequencer
  import nios_3pio_timer_sequencer_pkg::*;
#(
  parameter bit CONTINUOUS = 1'b1,
  parameter int COUNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         stop,
  input  logic [31:0]                  period_in,
  nios_3pio_timer_sequencer_if.master  tmr,
  output logic                         busy,
  output logic                         tick,
  output logic [COUNT_W-1:0]           tick_count
);

  state_t      state, next_state;
  logic [31:0] period_q, period_next;
  logic        stop_pend;
  logic        accept_start;
  logic        cs_d;
  logic [2:0]  addr_d;
  logic [15:0] data_d;

  assign accept_start = (state == ST_IDLE) && start;
  assign period_next  = accept_start ? period_in : period_q;

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (start) next_state = ST_WR_PL;
      ST_WR_PL:   next_state = ST_WR_PH;
      ST_WR_PH:   next_state = ST_WR_CLR;
      ST_WR_CLR:  next_state = ST_WR_CTRL;
      ST_WR_CTRL: next_state = ST_RUN;
      ST_RUN: begin
        // stop beats a simultaneous timeout; WR_FIN clears the pending status
        if (stop_pend || stop) next_state = ST_WR_STOP;
        else if (tmr.tmr_irq)  next_state = ST_ACK;
      end
      ST_ACK:     next_state = CONTINUOUS ? ST_RUN : ST_WR_FIN;
      ST_WR_STOP: next_state = ST_WR_FIN;
      ST_WR_FIN:  next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Bus values are decoded from next_state so the registered outputs line up
  // with the state they belong to.
  always_comb begin
    cs_d   = 1'b0;
    addr_d = TMR_STATUS;
    data_d = '0;
    case (next_state)
      ST_WR_PL: begin
        cs_d   = 1'b1;
        addr_d = TMR_PERIODL;
        data_d = period_next[15:0];
      end
      ST_WR_PH: begin
        cs_d   = 1'b1;
        addr_d = TMR_PERIODH;
        data_d = period_next[31:16];
      end
      ST_WR_CTRL: begin
        cs_d   = 1'b1;
        addr_d = TMR_CONTROL;
        data_d = ctrl_word(1'b1, CONTINUOUS, 1'b1, 1'b0);
      end
      ST_WR_STOP: begin
        cs_d   = 1'b1;
        addr_d = TMR_CONTROL;
        data_d = ctrl_word(1'b0, 1'b0, 1'b0, 1'b1);
      end
      ST_WR_CLR, ST_ACK, ST_WR_FIN: begin
        cs_d   = 1'b1;
        addr_d = TMR_STATUS;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= ST_IDLE;
      period_q           <= '0;
      stop_pend          <= 1'b0;
      busy               <= 1'b0;
      tick               <= 1'b0;
      tick_count         <= '0;
      tmr.tmr_chipselect <= 1'b0;
      tmr.tmr_write_n    <= 1'b1;
      tmr.tmr_address    <= TMR_STATUS;
      tmr.tmr_writedata  <= '0;
    end else begin
      state              <= next_state;
      period_q           <= period_next;
      busy               <= (next_state != ST_IDLE);
      tick               <= (next_state == ST_ACK);
      tmr.tmr_chipselect <= cs_d;
      tmr.tmr_write_n    <= ~cs_d;
      tmr.tmr_address    <= addr_d;
      tmr.tmr_writedata  <= data_d;

      if (accept_start)
        tick_count <= '0;
      else if (next_state == ST_ACK)
        tick_count <= tick_count + COUNT_W'(1);

      if (state == ST_WR_FIN)
        stop_pend <= 1'b0;
      else if (stop && (state inside {ST_WR_PL, ST_WR_PH, ST_WR_CLR, ST_WR_CTRL, ST_ACK}))
        stop_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nios_3pio_timer_sequencer.sv
// Directed bench: three sequencer instances (continuous, one-shot, 4-bit counter),
// each driving its own behavioural interval-timer model.
module tb_nios_3pio_timer_sequencer;

  localparam logic [20:0] IDLE_BUS = {1'b0, 1'b1, 3'd0, 16'h0000};

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  start;
  logic [2:0]  stop;
  logic [31:0] period_in [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam bit CONT = (g != 1);
    localparam int CW   = (g == 2) ? 4 : 16;

    nios_3pio_timer_sequencer_if bus ();
    logic          busy;
    logic          tick;
    logic [CW-1:0] tick_count;

    nios_3pio_timer_sequencer #(.CONTINUOUS(CONT), .COUNT_W(CW)) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start[g]),
      .stop       (stop[g]),
      .period_in  (period_in[g]),
      .tmr        (bus),
      .busy       (busy),
      .tick       (tick),
      .tick_count (tick_count)
    );

    // interval timer model: counts period..0, timeout set wins over a same-cycle clear
    logic [15:0] per_l, per_h;
    logic [31:0] cnt;
    logic        running, cont_q, ito_q, to_q;
    wire         wr = bus.tmr_chipselect && !bus.tmr_write_n;

    assign bus.tmr_irq = to_q && ito_q;

    always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        per_l <= '0; per_h <= '0; cnt <= '0;
        running <= 1'b0; cont_q <= 1'b0; ito_q <= 1'b0; to_q <= 1'b0;
      end else begin
        if (wr && bus.tmr_address == 3'd0) to_q <= 1'b0;
        if (wr && bus.tmr_address == 3'd2) per_l <= bus.tmr_writedata;
        if (wr && bus.tmr_address == 3'd3) per_h <= bus.tmr_writedata;
        if (running) begin
          if (cnt == 0) begin
            to_q <= 1'b1;
            if (cont_q) cnt <= {per_h, per_l};
            else        running <= 1'b0;
          end else begin
            cnt <= cnt - 1;
          end
        end
        if (wr && bus.tmr_address == 3'd1) begin
          ito_q  <= bus.tmr_writedata[0];
          cont_q <= bus.tmr_writedata[1];
          if (bus.tmr_writedata[2]) begin
            running <= 1'b1;
            cnt     <= {per_h, per_l};
          end
          if (bus.tmr_writedata[3]) running <= 1'b0;
        end
      end
    end

    wire [20:0] bw = {bus.tmr_chipselect, bus.tmr_write_n, bus.tmr_address, bus.tmr_writedata};

    int   n_tick = 0, n_stat = 0, n_dbl = 0;
    logic tick_d = 1'b0;
    always @(negedge clk) begin
      if (tick) n_tick <= n_tick + 1;
      if (tick && tick_d) n_dbl <= n_dbl + 1;
      tick_d <= tick;
      if (wr && bus.tmr_address == 3'd0) n_stat <= n_stat + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = '0;
    stop    = '0;
    for (int i = 0; i < 3; i++) period_in[i] = '0;
    step();
    step();
    checks++;
    if ({g_dut[0].busy, g_dut[0].tick, g_dut[0].tick_count, g_dut[0].bw} !== {2'b00, 16'h0, IDLE_BUS}) begin
      errors++;
      $display("FAIL reset_inst0: got %h want %h", {g_dut[0].busy, g_dut[0].tick, g_dut[0].tick_count, g_dut[0].bw}, {2'b00, 16'h0, IDLE_BUS});
    end
    checks++;
    if ({g_dut[1].busy, g_dut[1].tick, g_dut[1].tick_count, g_dut[1].bw} !== {2'b00, 16'h0, IDLE_BUS}) begin
      errors++;
      $display("FAIL reset_inst1: got %h want %h", {g_dut[1].busy, g_dut[1].tick, g_dut[1].tick_count, g_dut[1].bw}, {2'b00, 16'h0, IDLE_BUS});
    end
    checks++;
    if ({g_dut[2].busy, g_dut[2].tick, g_dut[2].tick_count, g_dut[2].bw} !== {2'b00, 4'h0, IDLE_BUS}) begin
      errors++;
      $display("FAIL reset_inst2: got %h want %h", {g_dut[2].busy, g_dut[2].tick, g_dut[2].tick_count, g_dut[2].bw}, {2'b00, 4'h0, IDLE_BUS});
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_config();
    int cyc;
    period_in[0] = 32'd9;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    checks++;
    if ({g_dut[0].busy, g_dut[0].bw} !== {1'b1, 1'b1, 1'b0, 3'd2, 16'h0009}) begin
      errors++;
      $display("FAIL cfg_period_l: got %h want %h", {g_dut[0].busy, g_dut[0].bw}, {1'b1, 1'b1, 1'b0, 3'd2, 16'h0009});
    end
    step();
    checks++;
    if (g_dut[0].bw !== {1'b1, 1'b0, 3'd3, 16'h0000}) begin
      errors++;
      $display("FAIL cfg_period_h: got %h want %h", g_dut[0].bw, {1'b1, 1'b0, 3'd3, 16'h0000});
    end
    step();
    checks++;
    if (g_dut[0].bw !== {1'b1, 1'b0, 3'd0, 16'h0000}) begin
      errors++;
      $display("FAIL cfg_clear: got %h want %h", g_dut[0].bw, {1'b1, 1'b0, 3'd0, 16'h0000});
    end
    step();
    checks++;
    if (g_dut[0].bw !== {1'b1, 1'b0, 3'd1, 16'h0007}) begin
      errors++;
      $display("FAIL cfg_ctrl_cont: got %h want %h", g_dut[0].bw, {1'b1, 1'b0, 3'd1, 16'h0007});
    end
    step();
    checks++;
    if ({g_dut[0].busy, g_dut[0].bw} !== {1'b1, IDLE_BUS}) begin
      errors++;
      $display("FAIL run_bus_idle: got %h want %h", {g_dut[0].busy, g_dut[0].bw}, {1'b1, IDLE_BUS});
    end
    cyc = 0;
    while (!g_dut[0].tick && cyc < 40) begin step(); cyc++; end
    checks++;
    if (cyc != 11) begin
      errors++;
      $display("FAIL first_tick_latency: got %0d cycles want 11", cyc);
    end
    checks++;
    if ({g_dut[0].tick_count, g_dut[0].bw} !== {16'd1, 1'b1, 1'b0, 3'd0, 16'h0000}) begin
      errors++;
      $display("FAIL first_ack: got %h want %h", {g_dut[0].tick_count, g_dut[0].bw}, {16'd1, 1'b1, 1'b0, 3'd0, 16'h0000});
    end
  endtask

  // continues the run begun by test_config (one tick already seen)
  task automatic test_continuous(input int stat0, input int tick0, input int dbl0);
    int cyc;
    for (int k = 2; k <= 5; k++) begin
      step();
      cyc = 0;
      while (!g_dut[0].tick && cyc < 40) begin step(); cyc++; end
      checks++;
      if (cyc != 9) begin
        errors++;
        $display("FAIL tick_interval_%0d: got %0d cycles want 9", k, cyc);
      end
    end
    step();
    checks++;
    if (g_dut[0].tick_count !== 16'd5) begin
      errors++;
      $display("FAIL cont_tick_count: got %0d want 5", g_dut[0].tick_count);
    end
    checks++;
    if ({g_dut[0].n_tick - tick0, g_dut[0].n_stat - stat0, g_dut[0].n_dbl - dbl0} !== {32'd5, 32'd6, 32'd0}) begin
      errors++;
      $display("FAIL cont_counts: ticks %0d status_writes %0d double %0d want 5 6 0",
               g_dut[0].n_tick - tick0, g_dut[0].n_stat - stat0, g_dut[0].n_dbl - dbl0);
    end
    stop[0] = 1'b1;
    step();
    stop[0] = 1'b0;
    checks++;
    if ({g_dut[0].tick, g_dut[0].bw} !== {1'b0, 1'b1, 1'b0, 3'd1, 16'h0008}) begin
      errors++;
      $display("FAIL run_stop_ctrl: got %h want %h", {g_dut[0].tick, g_dut[0].bw}, {1'b0, 1'b1, 1'b0, 3'd1, 16'h0008});
    end
    step();
    checks++;
    if ({g_dut[0].busy, g_dut[0].bw} !== {1'b1, 1'b1, 1'b0, 3'd0, 16'h0000}) begin
      errors++;
      $display("FAIL run_stop_fin: got %h want %h", {g_dut[0].busy, g_dut[0].bw}, {1'b1, 1'b1, 1'b0, 3'd0, 16'h0000});
    end
    step();
    checks++;
    if ({g_dut[0].busy, g_dut[0].bw} !== {1'b0, IDLE_BUS}) begin
      errors++;
      $display("FAIL run_stop_idle: got %h want %h", {g_dut[0].busy, g_dut[0].bw}, {1'b0, IDLE_BUS});
    end
  endtask

  task automatic test_stop_with_irq();
    int cyc, tick0;
    tick0 = g_dut[0].n_tick;
    period_in[0] = 32'd4;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    repeat (4) step();
    cyc = 0;
    while (!g_dut[0].bus.tmr_irq && cyc < 40) begin step(); cyc++; end
    checks++;
    if (cyc != 5) begin
      errors++;
      $display("FAIL irq_wait: got %0d cycles want 5", cyc);
    end
    stop[0] = 1'b1;
    step();
    stop[0] = 1'b0;
    checks++;
    if ({g_dut[0].tick, g_dut[0].bw} !== {1'b0, 1'b1, 1'b0, 3'd1, 16'h0008}) begin
      errors++;
      $display("FAIL stop_irq_ctrl: got %h want %h", {g_dut[0].tick, g_dut[0].bw}, {1'b0, 1'b1, 1'b0, 3'd1, 16'h0008});
    end
    step();
    checks++;
    if ({g_dut[0].tick, g_dut[0].bw} !== {1'b0, 1'b1, 1'b0, 3'd0, 16'h0000}) begin
      errors++;
      $display("FAIL stop_irq_fin: got %h want %h", {g_dut[0].tick, g_dut[0].bw}, {1'b0, 1'b1, 1'b0, 3'd0, 16'h0000});
    end
    step();
    checks++;
    if ({g_dut[0].busy, g_dut[0].bus.tmr_irq, g_dut[0].tick_count, g_dut[0].n_tick - tick0} !== {1'b0, 1'b0, 16'd0, 32'd0}) begin
      errors++;
      $display("FAIL stop_irq_end: busy %b irq %b count %0d ticks %0d want 0 0 0 0",
               g_dut[0].busy, g_dut[0].bus.tmr_irq, g_dut[0].tick_count, g_dut[0].n_tick - tick0);
    end
  endtask

  task automatic test_stop_pending();
    period_in[0] = 32'd20;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    step();
    stop[0] = 1'b1;
    start[0] = 1'b1;
    period_in[0] = 32'd99;
    step();
    stop[0] = 1'b0;
    start[0] = 1'b0;
    checks++;
    if (g_dut[0].bw !== {1'b1, 1'b0, 3'd0, 16'h0000}) begin
      errors++;
      $display("FAIL pend_clear: got %h want %h", g_dut[0].bw, {1'b1, 1'b0, 3'd0, 16'h0000});
    end
    step();
    checks++;
    if (g_dut[0].bw !== {1'b1, 1'b0, 3'd1, 16'h0007}) begin
      errors++;
      $display("FAIL pend_ctrl: got %h want %h", g_dut[0].bw, {1'b1, 1'b0, 3'd1, 16'h0007});
    end
    step();
    checks++;
    if ({g_dut[0].busy, g_dut[0].bw} !== {1'b1, IDLE_BUS}) begin
      errors++;
      $display("FAIL pend_run: got %h want %h", {g_dut[0].busy, g_dut[0].bw}, {1'b1, IDLE_BUS});
    end
    step();
    checks++;
    if (g_dut[0].bw !== {1'b1, 1'b0, 3'd1, 16'h0008}) begin
      errors++;
      $display("FAIL pend_stop: got %h want %h", g_dut[0].bw, {1'b1, 1'b0, 3'd1, 16'h0008});
    end
    step();
    step();
    checks++;
    if ({g_dut[0].busy, g_dut[0].u_dut.period_q} !== {1'b0, 32'd20}) begin
      errors++;
      $display("FAIL pend_end: busy %b period_q %0d want 0 20", g_dut[0].busy, g_dut[0].u_dut.period_q);
    end
  endtask

  task automatic test_one_shot();
    int cyc, tick0;
    tick0 = g_dut[1].n_tick;
    period_in[1] = 32'd3;
    start[1] = 1'b1;
    step();
    start[1] = 1'b0;
    checks++;
    if (g_dut[1].bw !== {1'b1, 1'b0, 3'd2, 16'h0003}) begin
      errors++;
      $display("FAIL os_period_l: got %h want %h", g_dut[1].bw, {1'b1, 1'b0, 3'd2, 16'h0003});
    end
    repeat (3) step();
    checks++;
    if (g_dut[1].bw !== {1'b1, 1'b0, 3'd1, 16'h0005}) begin
      errors++;
      $display("FAIL os_ctrl: got %h want %h", g_dut[1].bw, {1'b1, 1'b0, 3'd1, 16'h0005});
    end
    step();
    cyc = 0;
    while (!g_dut[1].tick && cyc < 40) begin step(); cyc++; end
    checks++;
    if ({cyc, g_dut[1].tick_count} !== {32'd5, 16'd1}) begin
      errors++;
      $display("FAIL os_tick: got %0d cycles count %0d want 5 1", cyc, g_dut[1].tick_count);
    end
    step();
    checks++;
    if ({g_dut[1].busy, g_dut[1].tick, g_dut[1].bw} !== {1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000}) begin
      errors++;
      $display("FAIL os_fin: got %h want %h", {g_dut[1].busy, g_dut[1].tick, g_dut[1].bw}, {1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000});
    end
    step();
    checks++;
    if ({g_dut[1].busy, g_dut[1].bw} !== {1'b0, IDLE_BUS}) begin
      errors++;
      $display("FAIL os_idle: got %h want %h", {g_dut[1].busy, g_dut[1].bw}, {1'b0, IDLE_BUS});
    end
    repeat (20) step();
    checks++;
    if ({g_dut[1].tick_count, g_dut[1].n_tick - tick0} !== {16'd1, 32'd1}) begin
      errors++;
      $display("FAIL os_quiet: count %0d ticks %0d want 1 1", g_dut[1].tick_count, g_dut[1].n_tick - tick0);
    end
  endtask

  task automatic test_wrap_and_reset();
    int cyc, nt;
    period_in[2] = 32'd0;
    start[2] = 1'b1;
    step();
    start[2] = 1'b0;
    repeat (4) step();
    cyc = 0;
    nt  = 0;
    while (nt < 17 && cyc < 100) begin
      step();
      cyc++;
      if (g_dut[2].tick) nt++;
    end
    checks++;
    if (cyc != 34) begin
      errors++;
      $display("FAIL wrap_timing: got %0d cycles want 34", cyc);
    end
    checks++;
    if (g_dut[2].tick_count !== 4'd1) begin
      errors++;
      $display("FAIL wrap_count: got %0d want 1", g_dut[2].tick_count);
    end
    step();
    checks++;
    if ({g_dut[2].busy, g_dut[2].tick_count} !== {1'b1, 4'd1}) begin
      errors++;
      $display("FAIL pre_reset_run: got %h want %h", {g_dut[2].busy, g_dut[2].tick_count}, {1'b1, 4'd1});
    end
    reset_n = 1'b0;
    #2;
    checks++;
    if ({g_dut[2].busy, g_dut[2].tick, g_dut[2].tick_count, g_dut[2].bw, g_dut[2].bus.tmr_irq} !== {2'b00, 4'd0, IDLE_BUS, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got %h want %h",
               {g_dut[2].busy, g_dut[2].tick, g_dut[2].tick_count, g_dut[2].bw, g_dut[2].bus.tmr_irq},
               {2'b00, 4'd0, IDLE_BUS, 1'b0});
    end
    #3;
    reset_n = 1'b1;
    repeat (3) step();
    checks++;
    if ({g_dut[2].busy, g_dut[2].tick_count, g_dut[2].bw} !== {1'b0, 4'd0, IDLE_BUS}) begin
      errors++;
      $display("FAIL post_reset_idle: got %h want %h", {g_dut[2].busy, g_dut[2].tick_count, g_dut[2].bw}, {1'b0, 4'd0, IDLE_BUS});
    end
  endtask

  initial begin
    int stat0, tick0, dbl0;
    test_reset();
    stat0 = g_dut[0].n_stat;
    tick0 = g_dut[0].n_tick;
    dbl0  = g_dut[0].n_dbl;
    test_config();
    test_continuous(stat0, tick0, dbl0);
    test_stop_with_irq();
    test_stop_pending();
    test_one_shot();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nios_3pio_timer_sequencer.md
# nios_3pio_timer_sequencer

Hardware Avalon-MM master that programs and services the 3-PIO interval timer without CPU involvement. Sits directly upstream of the timer slave port: it writes the period and control registers, starts the timer, and acknowledges each timeout interrupt. Every acknowledged timeout becomes a single-cycle `tick` pulse and increments a tick counter for downstream logic.

## Interface
- `CONTINUOUS`, 1: 1 = timer reloads forever; 0 = one-shot, sequencer returns to IDLE after the first tick.
- `COUNT_W`, 16: width of `tick_count`.

- `clk` in 1: single system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request; honoured only in IDLE.
- `stop` in 1: one-cycle request; ignored in IDLE.
- `period_in` in 32: timer period minus one (counts N..0), latched on an accepted `start`.
- `tmr_irq` in 1: timer interrupt, level, cleared by a status write.
- `tmr_address` out 3: timer register address.
- `tmr_chipselect` out 1: high only on a write cycle.
- `tmr_write_n` out 1: active-low write strobe.
- `tmr_writedata` out 16: write data.
- `busy` out 1: high in every state except IDLE.
- `tick` out 1: one-cycle pulse per acknowledged timeout.
- `tick_count` out COUNT_W: acknowledged timeouts since the last accepted `start`; wraps.

## Operation
- Timer map: 0 = status (any write clears timeout); 1 = control (b0 ITO, b1 CONT, b2 START, b3 STOP); 2 = period_l; 3 = period_h. The slave has no waitrequest, so every write completes in one cycle.
- All `tmr_*` outputs and `busy`, `tick`, `tick_count` are registered, decoded from state.
- FSM states: IDLE, WR_PL, WR_PH, WR_CLR, WR_CTRL, RUN, ACK, WR_STOP, WR_FIN.
- IDLE: on `start`, latch `period_in` into `period_q`, zero `tick_count`, go to WR_PL.
- WR_PL: write addr 2, data `period_q[15:0]`.
- WR_PH: write addr 3, data `period_q[31:16]`.
- WR_CLR: write addr 0 to clear any stale timeout.
- WR_CTRL: write addr 1, data `{1'b0, 1'b1, CONTINUOUS, 1'b1}`, i.e. 4'h7 or 4'h5.
- Each write state lasts exactly one cycle and moves to the next listed state.
- RUN: waits for `tmr_irq`.
  - Pending stop or `stop` goes to WR_STOP.
  - Otherwise `tmr_irq` goes to ACK.
- ACK: write addr 0, pulse `tick`, `tick_count` += 1 modulo 2^COUNT_W. Next state is RUN if CONTINUOUS, else WR_FIN.
- WR_STOP: write addr 1, data 4'h8 (stop, interrupt disabled), then WR_FIN.
- WR_FIN: write addr 0, then IDLE.
- Idle bus values: `tmr_chipselect`=0, `tmr_write_n`=1, `tmr_address`=0, `tmr_writedata`=0.
- Boundary rules:
  - A `stop` during WR_PL..WR_CTRL sets `stop_pend`. It is serviced on entry to RUN: RUN lasts one cycle, then WR_STOP. `stop_pend` clears in WR_FIN.
  - `stop` and `tmr_irq` in the same RUN cycle: stop wins, no `tick`, and the timeout is cleared in WR_FIN.
  - `start` while `busy` is ignored.
  - `period_in` = 0 is legal: the timer times out continuously and ticks occur every 2 cycles (RUN, ACK).
  - `tick_count` wraps from all-ones to 0 with no flag.

## Timing
- Reset values: state IDLE, `busy`=0, `tick`=0, `tick_count`=0, `period_q`=0, `stop_pend`=0, bus idle.
- `start` sampled high in cycle T gives WR_PL in T+1 and WR_CTRL in T+4. The timer begins counting at T+5.
- `tmr_irq` seen in RUN at cycle T gives ACK (with `tick`) in T+1. The timer drops `irq` at T+2, so RUN never double-counts one timeout.
- One-shot: ACK, WR_FIN, then IDLE, with `busy` low 2 cycles after `tick`.
- `stop` in RUN at T: WR_STOP at T+1, WR_FIN at T+2, IDLE (`busy`=0) at T+3.
- Reset mid-operation returns immediately to the reset values. The timer is assumed reset by the same `reset_n`.

## Structure
- The shared package holds:
  - timer register addresses (STATUS=0, CONTROL=1, PERIODL=2, PERIODH=3),
  - control bit positions,
  - the FSM state enumeration.
- No sub-module: a single FSM plus datapath registers.

## Test plan
- Reset, then `start` with `period_in`=9 and CONTINUOUS=1 -> writes 0009, 0000, status, 0007 on consecutive cycles; first `tick` about 11 cycles after the start of counting.
- Continuous run for 5 timeouts -> `tick_count`=5, exactly one status write per irq, no double ticks.
- CONTINUOUS=0, `period_in`=3 -> one `tick`, then WR_FIN; `busy` falls 2 cycles after `tick`.
- `stop` asserted in the same cycle as `tmr_irq` -> no `tick`; writes control 0x8 then status; IDLE 3 cycles later.
- `stop` during WR_PH -> configuration completes, one RUN cycle, then the stop sequence; `start` during `busy` is ignored (`period_q` unchanged).
- COUNT_W=4, 17 timeouts -> `tick_count`=1; `reset_n` pulsed mid-RUN -> all outputs return to reset values asynchronously.
